// File: rtl/vmem_wr_arb.sv
// vmem_wr_arb: two-requester arbiter/sequencer for the video-memory write
// FIFO port. Requester 0 is the CPU write path and requester 1 is a bulk
// writer (pattern generator / fill engine). Ownership is granted in bounded
// bursts so that neither side starves. The winning beat is registered onto
// the FIFO write port. i_afull stalls issue without losing beats.
//
// Optional build macro VMEM_WR_ARB_STATS_EN adds two 16-bit accepted-beat
// counters (o_stat_r0, o_stat_r1) and a synchronous clear input (i_stat_clr).
module vmem_wr_arb #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_afull,

    input  logic        i_r0_valid,
    output logic        o_r0_ready,
    input  logic [15:0] i_r0_addr,
    input  logic [7:0]  i_r0_data,
    input  logic        i_r0_up_n,
    input  logic        i_r0_lo_n,

    input  logic        i_r1_valid,
    output logic        o_r1_ready,
    input  logic [15:0] i_r1_addr,
    input  logic [7:0]  i_r1_data,
    input  logic        i_r1_up_n,
    input  logic        i_r1_lo_n,

`ifdef VMEM_WR_ARB_STATS_EN
    input  logic        i_stat_clr,
    output logic [15:0] o_stat_r0,
    output logic [15:0] o_stat_r1,
`endif

    output logic        o_wr_n,
    output logic [15:0] o_addr,
    output logic        o_vmem_up_n,
    output logic        o_vmem_lo_n,
    output logic [7:0]  o_vmem_data,
    output logic [1:0]  o_gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             acc0;
    logic             acc1;
    logic             acc;
    logic             limit;

    // Ready is a pure function of the registered owner and backpressure.
    assign o_r0_ready = (state == OWN0) & ~i_afull;
    assign o_r1_ready = (state == OWN1) & ~i_afull;

    assign acc0 = i_r0_valid & o_r0_ready;
    assign acc1 = i_r1_valid & o_r1_ready;
    assign acc  = acc0 | acc1;

    // Burst count including this cycle's accept, saturating at MAX_BURST.
    // No accept can happen while i_afull is high, so the count is frozen then.
    assign cnt_inc = (acc && (cnt != MAX_CNT)) ? cnt + 1'b1 : cnt;

    // The limit is judged on the count including the current beat, so the
    // owner hands over right after its MAX_BURST-th beat instead of
    // squeezing in one extra beat on the handover cycle.
    assign limit = (cnt_inc == MAX_CNT);

    // Ownership FSM: owner state, registered grant and burst counter.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            o_gnt <= 2'b00;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (i_r0_valid) begin
                        state <= OWN0;
                        o_gnt <= 2'b01;
                    end else if (i_r1_valid) begin
                        state <= OWN1;
                        o_gnt <= 2'b10;
                    end
                end
                OWN0: begin
                    if (!i_r0_valid || (limit && i_r1_valid)) begin
                        // Direct switch to the other side when it is waiting.
                        cnt <= '0;
                        if (i_r1_valid) begin
                            state <= OWN1;
                            o_gnt <= 2'b10;
                        end else begin
                            state <= IDLE;
                            o_gnt <= 2'b00;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                OWN1: begin
                    if (!i_r1_valid || (limit && i_r0_valid)) begin
                        cnt <= '0;
                        if (i_r0_valid) begin
                            state <= OWN0;
                            o_gnt <= 2'b01;
                        end else begin
                            state <= IDLE;
                            o_gnt <= 2'b00;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    o_gnt <= 2'b00;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Write port: strobe for one cycle per accepted beat; payload holds otherwise.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wr_n      <= 1'b1;
            o_addr      <= '0;
            o_vmem_data <= '0;
            o_vmem_up_n <= 1'b1;
            o_vmem_lo_n <= 1'b1;
        end else begin
            o_wr_n <= ~acc;
            if (acc0) begin
                o_addr      <= i_r0_addr;
                o_vmem_data <= i_r0_data;
                o_vmem_up_n <= i_r0_up_n;
                o_vmem_lo_n <= i_r0_lo_n;
            end else if (acc1) begin
                o_addr      <= i_r1_addr;
                o_vmem_data <= i_r1_data;
                o_vmem_up_n <= i_r1_up_n;
                o_vmem_lo_n <= i_r1_lo_n;
            end
        end
    end

`ifdef VMEM_WR_ARB_STATS_EN
    // Accepted-beat counters; a clear coinciding with an accept counts that beat.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stat_r0 <= '0;
            o_stat_r1 <= '0;
        end else if (i_stat_clr) begin
            o_stat_r0 <= {15'd0, acc0};
            o_stat_r1 <= {15'd0, acc1};
        end else begin
            if (acc0) o_stat_r0 <= o_stat_r0 + 16'd1;
            if (acc1) o_stat_r1 <= o_stat_r1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vmem_wr_arb.sv
// tb_vmem_wr_arb: directed bench for vmem_wr_arb with MAX_BURST=4.
// Stimulus pushes the hand-ordered expected write beats into a scoreboard
// queue; a monitor pops and compares on every FIFO write strobe.
module tb_vmem_wr_arb;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        up_n;
        logic        lo_n;
    } beat_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_afull = 1'b0;
    logic        i_r0_valid = 1'b0, i_r1_valid = 1'b0;
    logic        o_r0_ready, o_r1_ready;
    logic [15:0] i_r0_addr = '0, i_r1_addr = '0;
    logic [7:0]  i_r0_data = '0, i_r1_data = '0;
    logic        i_r0_up_n = 1'b1, i_r0_lo_n = 1'b1;
    logic        i_r1_up_n = 1'b1, i_r1_lo_n = 1'b1;
    logic        o_wr_n, o_vmem_up_n, o_vmem_lo_n;
    logic [15:0] o_addr;
    logic [7:0]  o_vmem_data;
    logic [1:0]  o_gnt;
`ifdef VMEM_WR_ARB_STATS_EN
    logic        i_stat_clr = 1'b0;
    logic [15:0] o_stat_r0, o_stat_r1;
`endif

    vmem_wr_arb #(.MAX_BURST(4), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_afull(i_afull),
        .i_r0_valid(i_r0_valid), .o_r0_ready(o_r0_ready), .i_r0_addr(i_r0_addr),
        .i_r0_data(i_r0_data), .i_r0_up_n(i_r0_up_n), .i_r0_lo_n(i_r0_lo_n),
        .i_r1_valid(i_r1_valid), .o_r1_ready(o_r1_ready), .i_r1_addr(i_r1_addr),
        .i_r1_data(i_r1_data), .i_r1_up_n(i_r1_up_n), .i_r1_lo_n(i_r1_lo_n),
`ifdef VMEM_WR_ARB_STATS_EN
        .i_stat_clr(i_stat_clr), .o_stat_r0(o_stat_r0), .o_stat_r1(o_stat_r1),
`endif
        .o_wr_n(o_wr_n), .o_addr(o_addr), .o_vmem_up_n(o_vmem_up_n),
        .o_vmem_lo_n(o_vmem_lo_n), .o_vmem_data(o_vmem_data), .o_gnt(o_gnt)
    );

    always #5 i_clk = ~i_clk;

    beat_t src0[$], src1[$], exp_q[$];
    int    vec_cnt = 0;
    int    err_cnt = 0;
    logic  acc0_q = 1'b0, acc1_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic beat_t mk(input logic [15:0] a, input logic [7:0] d,
                                 input logic up, input logic lo);
        beat_t b;
        b.addr = a; b.data = d; b.up_n = up; b.lo_n = lo;
        return b;
    endfunction

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge i_clk) begin
        if (i_reset_n && o_wr_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {6'd0, o_addr, o_vmem_data, o_vmem_up_n, o_vmem_lo_n}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("wr_beat", {6'd0, o_addr, o_vmem_data, o_vmem_up_n, o_vmem_lo_n}, {6'd0, e});
            end
        end
    end

    // One cycle of requester drivers: retire accepted heads, present the next.
    task automatic step(input logic af);
        @(negedge i_clk);
        if (acc0_q) void'(src0.pop_front());
        if (acc1_q) void'(src1.pop_front());
        i_afull = af;
        i_r0_valid = (src0.size() > 0);
        if (src0.size() > 0) begin
            i_r0_addr = src0[0].addr; i_r0_data = src0[0].data;
            i_r0_up_n = src0[0].up_n; i_r0_lo_n = src0[0].lo_n;
        end
        i_r1_valid = (src1.size() > 0);
        if (src1.size() > 0) begin
            i_r1_addr = src1[0].addr; i_r1_data = src1[0].data;
            i_r1_up_n = src1[0].up_n; i_r1_lo_n = src1[0].lo_n;
        end
        #1;
        acc0_q = i_r0_valid & o_r0_ready;
        acc1_q = i_r1_valid & o_r1_ready;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((src0.size() > 0 || src1.size() > 0 || exp_q.size() > 0) && n < 300) begin
            step(1'b0);
            n++;
        end
        step(1'b0);
        step(1'b0);
        chk({name, "_left"}, exp_q.size(), 0);
    endtask

    initial begin
        beat_t b;
        logic  seen01, seen10;

        // Reset release with no requests: everything at reset values.
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            chk("rst_wr_n", o_wr_n, 1);
            chk("rst_gnt", o_gnt, 0);
            chk("rst_addr", o_addr, 0);
            chk("rst_data", o_vmem_data, 0);
            chk("rst_planes", {o_vmem_up_n, o_vmem_lo_n}, 2'b11);
        end

        // r0 alone: four beats, grant after one arbitration cycle, back-to-back strobes.
        for (int i = 0; i < 4; i++) begin
            b = mk(16'hC000 + 16'(i), 8'((1 << (i + 1)) - 1), 1'(i & 1), 1'((i >> 1) & 1));
            src0.push_back(b);
            exp_q.push_back(b);
        end
        step(1'b0);
        chk("r0_idle_ready", o_r0_ready, 0);
        step(1'b0);
        chk("r0_gnt", o_gnt, 2'b01);
        chk("r0_ready", o_r0_ready, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            chk("r0_consecutive", o_wr_n, 0);
        end
        drain("r0_only");
        chk("r0_back_idle", o_gnt, 0);

        // Both continuously valid: grants alternate in bursts of four.
        for (int i = 0; i < 32; i++) begin
            src0.push_back(mk(16'h1000 + 16'(i), 8'(i), 1'b0, 1'b1));
            src1.push_back(mk(16'h2000 + 16'(i), 8'(8'h80 + i), 1'b1, 1'b0));
        end
        for (int blk = 0; blk < 8; blk++) begin
            for (int j = 0; j < 4; j++) exp_q.push_back(mk(16'h1000 + 16'(blk*4+j), 8'(blk*4+j), 1'b0, 1'b1));
            for (int j = 0; j < 4; j++) exp_q.push_back(mk(16'h2000 + 16'(blk*4+j), 8'(8'h80 + blk*4+j), 1'b1, 1'b0));
        end
        drain("alt_burst");
`ifdef VMEM_WR_ARB_STATS_EN
        chk("stat_r0_total", o_stat_r0, 36);
        chk("stat_r1_total", o_stat_r1, 32);
`endif

        // afull for five cycles in the middle of an r1 burst.
        for (int i = 0; i < 6; i++) begin
            b = mk(16'h3000 + 16'(i), 8'(8'h40 + i), 1'(i & 1), 1'b0);
            src1.push_back(b);
            exp_q.push_back(b);
        end
        step(1'b0);
        step(1'b0);
        chk("r1_gnt", o_gnt, 2'b10);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("afull_ready", o_r1_ready, 0);
            chk("afull_gnt", o_gnt, 2'b10);
            if (i > 0) chk("afull_wr_n", o_wr_n, 1);
        end
        step(1'b0);
        chk("afull_wr_n_last", o_wr_n, 1);
        drain("afull");

        // r0 drops valid while r1 waits: direct handover without IDLE.
        src0.push_back(mk(16'h4000, 8'hA0, 1'b0, 1'b0));
        src0.push_back(mk(16'h4001, 8'hA1, 1'b1, 1'b1));
        src1.push_back(mk(16'h5000, 8'hB0, 1'b0, 1'b1));
        src1.push_back(mk(16'h5001, 8'hB1, 1'b1, 1'b0));
        exp_q.push_back(mk(16'h4000, 8'hA0, 1'b0, 1'b0));
        exp_q.push_back(mk(16'h4001, 8'hA1, 1'b1, 1'b1));
        exp_q.push_back(mk(16'h5000, 8'hB0, 1'b0, 1'b1));
        exp_q.push_back(mk(16'h5001, 8'hB1, 1'b1, 1'b0));
        seen01 = 1'b0;
        seen10 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            if (o_gnt == 2'b01) seen01 = 1'b1;
            if (o_gnt == 2'b10) seen10 = 1'b1;
            if (seen01 && src1.size() > 0) chk("no_idle_gap", (o_gnt == 2'b00), 0);
        end
        chk("handover_seen", {seen01, seen10}, 2'b11);
        drain("handover");

        // Async reset pulse mid-burst.
        for (int i = 0; i < 8; i++) begin
            b = mk(16'h6000 + 16'(i), 8'(8'h60 + i), 1'b0, 1'b0);
            src0.push_back(b);
            exp_q.push_back(b);
        end
        step(1'b0);
        step(1'b0);
`ifdef VMEM_WR_ARB_STATS_EN
        i_stat_clr = 1'b1;
        step(1'b0);
        i_stat_clr = 1'b0;
        chk("stat_clr_with_accept", o_stat_r0, 1);
`else
        step(1'b0);
`endif
        step(1'b0);
        @(posedge i_clk);
        #3;
        i_reset_n = 1'b0;
        #1;
        chk("arst_wr_n", o_wr_n, 1);
        chk("arst_gnt", o_gnt, 0);
        chk("arst_addr", o_addr, 0);
        chk("arst_data", o_vmem_data, 0);
`ifdef VMEM_WR_ARB_STATS_EN
        chk("arst_stat", {o_stat_r1, o_stat_r0}, 0);
`endif
        src0.delete();
        src1.delete();
        exp_q.delete();
        acc0_q = 1'b0;
        acc1_q = 1'b0;
        i_r0_valid = 1'b0;
        i_r1_valid = 1'b0;
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            chk("post_rst_wr_n", o_wr_n, 1);
            chk("post_rst_gnt", o_gnt, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
